// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_pkg : shared inter-stage field layout, ctrl indices, occupancy codes |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
package pipe_pkg;

  // EX/MEM payload layout, LSB first: Databus3, ALUOut, PC, rd
  localparam int EXMEM_DATA_W       = 101;
  localparam int EXMEM_CTRL_W       = 5;
  localparam int EXMEM_DATABUS3_LSB = 0;
  localparam int EXMEM_ALUOUT_LSB   = 32;
  localparam int EXMEM_PC_LSB       = 64;
  localparam int EXMEM_RD_LSB       = 96;
  localparam int EXMEM_RD_W         = 5;
  localparam int EXMEM_WORD_W       = 32;

  localparam int CTRL_REGWRITE      = 4;
  localparam int CTRL_MEMREAD       = 3;
  localparam int CTRL_MEMWRITE      = 2;
  localparam int CTRL_MEMTOREG_LSB  = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // The skid slot only ever fills behind a valid main slot.
  function automatic logic [1:0] occ_count(input logic m_valid, input logic s_valid);
    occ_e occ;
    if (s_valid)      occ = OCC_TWO;
    else if (m_valid) occ = OCC_ONE;
    else              occ = OCC_EMPTY;
    return occ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_slot : valid+data+ctrl register with load enable and sync clear     |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int CTRL_W = EXMEM_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  // Clear kills valid and ctrl only; data is left in place.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = valid_i;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_reg : valid/ready pipeline register, optional 2-entry skid    |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = EXMEM_DATA_W,
  parameter int CTRL_W  = EXMEM_CTRL_W,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              w_accept, w_release;
  logic              w_m_valid, w_m_load, w_m_clear;
  logic [DATA_W-1:0] w_m_data, w_m_data_in;
  logic [CTRL_W-1:0] w_m_ctrl, w_m_ctrl_in;
  logic              w_s_valid;
  logic [DATA_W-1:0] w_s_data;
  logic [CTRL_W-1:0] w_s_ctrl;

  assign w_accept  = in_valid & in_ready;
  assign w_release = w_m_valid & out_ready;

  // M refills from S when draining a full stage, otherwise from the input.
  assign w_m_load    = ~flush & ((w_release & w_s_valid) |
                                 (w_accept & (~w_m_valid | w_release)));
  assign w_m_clear   = flush | (w_release & ~w_s_valid & ~w_accept);
  assign w_m_data_in = w_s_valid ? w_s_data : in_data;
  assign w_m_ctrl_in = w_s_valid ? w_s_ctrl : in_ctrl;

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_slot_m (
    .clk     (clk),
    .reset   (reset),
    .load_i  (w_m_load),
    .clear_i (w_m_clear),
    .valid_i (1'b1),
    .data_i  (w_m_data_in),
    .ctrl_i  (w_m_ctrl_in),
    .valid_o (w_m_valid),
    .data_o  (w_m_data),
    .ctrl_o  (w_m_ctrl)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic w_s_load, w_s_clear;

      assign w_s_load  = ~flush & w_accept & w_m_valid & ~w_release;
      assign w_s_clear = flush | (w_release & w_s_valid);

      pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_slot_s (
        .clk     (clk),
        .reset   (reset),
        .load_i  (w_s_load),
        .clear_i (w_s_clear),
        .valid_i (1'b1),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .valid_o (w_s_valid),
        .data_o  (w_s_data),
        .ctrl_o  (w_s_ctrl)
      );

      // Registered ready: no combinational path from out_ready.
      assign in_ready = ~w_s_valid;
    end else begin : g_no_skid
      assign w_s_valid = 1'b0;
      assign w_s_data  = '0;
      assign w_s_ctrl  = '0;
      assign in_ready  = ~w_m_valid | out_ready;
    end
  endgenerate

  assign out_valid = w_m_valid;
  assign out_data  = w_m_data;
  assign out_ctrl  = w_m_ctrl & {CTRL_W{w_m_valid}};
  assign occupancy = occ_count(w_m_valid, w_s_valid);

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_stage_reg : scoreboard bench for skid and no-skid builds         |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_reg;

  localparam int DW = 101;
  localparam int CW = 5;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_ready;

  logic [1:0]    ir, ov;
  logic [DW-1:0] od  [2];
  logic [CW-1:0] oc  [2];
  logic [1:0]    occ [2];

  int n_cmp = 0;
  int n_bad = 0;

  ent_t          mq     [2][$];
  logic [DW-1:0] last_m [2];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_ctrl(oc[1]), .occupancy(occ[1])
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_ctrl(oc[0]), .occupancy(occ[0])
  );

  task automatic chk(input string name, input int k, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (skid=%0d) t=%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // Monitor + reference model: the stage is a FIFO of depth 2 (skid) or 1.
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        last_m[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int   sz;
        bit   rdy;
        ent_t e;
        sz  = mq[k].size();
        rdy = (k == 1) ? (sz < 2) : (sz == 0 || out_ready);
        chk("out_valid", k, 128'(ov[k]), 128'(sz != 0));
        chk("occupancy", k, 128'(occ[k]), 128'(sz));
        chk("in_ready",  k, 128'(ir[k]), 128'(rdy));
        if (sz != 0) begin
          last_m[k] = mq[k][0].d;
          chk("out_data", k, 128'(od[k]), 128'(mq[k][0].d));
          chk("out_ctrl", k, 128'(oc[k]), 128'(mq[k][0].c));
          if (out_ready) void'(mq[k].pop_front());
        end else begin
          chk("held_data",   k, 128'(od[k]), 128'(last_m[k]));
          chk("bubble_ctrl", k, 128'(oc[k]), 128'(0));
        end
        if (flush) begin
          mq[k].delete();
        end else if (in_valid && rdy) begin
          e.d = in_data;
          e.c = in_ctrl;
          mq[k].push_back(e);
        end
        if (mq[k].size() != 0) last_m[k] = mq[k][0].d;
      end
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit ordy, input bit fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", k, 128'(ov[k]), 128'(0));
      chk("rst_out_data",  k, 128'(od[k]), 128'(0));
      chk("rst_out_ctrl",  k, 128'(oc[k]), 128'(0));
      chk("rst_occupancy", k, 128'(occ[k]), 128'(0));
      chk("rst_in_ready",  k, 128'(ir[k]), 128'(1));
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    reset = 1'b0;
    drive(0, '0, '0, 1, 0);

    // Streaming, no backpressure
    for (int i = 1; i <= 4; i++) drive(1, DW'(i), 5'b10001, 1, 0);
    drive(0, '0, '0, 1, 0);

    // Backpressure then drain
    for (int i = 0; i < 3; i++) drive(1, DW'(16 + i), 5'b01100, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, '0, '0, 1, 0);

    // Fill, then flush while an input is offered
    drive(1, DW'(32), 5'b11111, 0, 0);
    drive(1, DW'(33), 5'b11110, 0, 0);
    drive(1, DW'(34), 5'b10101, 0, 1);
    drive(0, '0, '0, 1, 0);
    drive(0, '0, '0, 1, 0);

    // Bubble: drained entry leaves its data on the bus
    drive(1, DW'(12'hABC), 5'b10011, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, '0, '0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 3) != 0), rand_data(), CW'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));

    // Asynchronous reset with the skid stage full
    drive(1, DW'(48), 5'b11001, 0, 0);
    drive(1, DW'(49), 5'b11010, 0, 0);
    drive(0, '0, '0, 0, 0);
    chk("pre_reset_occupancy", 1, 128'(occ[1]), 128'(2));
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) drive(1, DW'(64 + i), 5'b00111, (i % 2) == 0, 0);
    for (int i = 0; i < 4; i++) drive(0, '0, '0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
